// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding, command field widths and command type constants
package spi_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, GAP} state_e;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int FREQ_W = 10;
    localparam int CMD_W  = 1 + ADDR_W + DATA_W;
    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;
endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous command FIFO holding {rw, addr, wdata}; no bypass, head read combinationally
module spi_cmd_fifo
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clock_i,
    input  logic             n_reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CMD_W-1:0] din_i,
    output logic [CMD_W-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);
    logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
    logic [LW-2:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = level_q == LW'(FIFO_DEPTH);
    assign empty_o = level_q == '0;
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_q];
    // a full FIFO refuses pushes even when a pop frees a slot in the same cycle
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clock_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= do_push ? wr_q + 1'b1 : wr_q;
            rd_q    <= do_pop ? rd_q + 1'b1 : rd_q;
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: queues read/write commands, drives spi_master start pulses,
// tracks ss for completion/timeout and returns one ordered response per command.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int START_CYCLES = 10,
    parameter int GAP_CYCLES   = 16,
    parameter int TIMEOUT      = 4096,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clock_i,
    input  logic              n_reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_rw_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    input  logic [FREQ_W-1:0] cfg_freq_i,
    output logic              rsp_valid_o,
    output logic              rsp_rw_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_timeout_o,
    output logic              busy_o,
    output logic [LW-1:0]     level_o,
    output logic              spi_start_wr_o,
    output logic              spi_start_re_o,
    output logic [ADDR_W-1:0] spi_addr_o,
    output logic [DATA_W-1:0] spi_wdata_o,
    output logic [FREQ_W-1:0] spi_freq_o,
    input  logic [DATA_W-1:0] spi_rdata_i,
    input  logic              spi_ss_i
);
    localparam int CW = $clog2(TIMEOUT + START_CYCLES + GAP_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ss_dly_q, early_q, early_d, rw_q, rw_d, timeout_q, timeout_d, valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [CMD_W-1:0]  head;
    logic              full, empty, pop, ss_fall, ss_rise;

    assign ss_fall = ss_dly_q & ~spi_ss_i;
    assign ss_rise = ~ss_dly_q & spi_ss_i;
    assign pop     = (state_q == IDLE) & ~empty;

    spi_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i  (clock_i),
        .n_reset_i(n_reset_i),
        .push_i   (cmd_valid_i),
        .pop_i    (pop),
        .din_i    ({cmd_rw_i, cmd_addr_i, cmd_wdata_i}),
        .dout_o   (head),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level_o)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        early_d   = early_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        freq_d    = freq_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    state_d                 = LAUNCH;
                    {rw_d, addr_d, wdata_d} = head;
                    freq_d                  = cfg_freq_i;
                    early_d                 = 1'b0;
                end
            end
            LAUNCH: begin
                early_d = early_q | ss_fall;
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    state_d = (early_q | ss_fall) ? WAIT_HIGH : WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (ss_fall) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = GAP;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (ss_rise) begin
                    state_d   = GAP;
                    cnt_d     = '0;
                    rdata_d   = (rw_q == CMD_RD) ? spi_rdata_i : '0;
                    timeout_d = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = GAP;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // registered pulse lands on the last GAP cycle
        valid_d = (state_d == GAP) && (cnt_d == CW'(GAP_CYCLES - 1));
    end

    always_ff @(posedge clock_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ss_dly_q  <= 1'b1;
            early_q   <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            freq_q    <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ss_dly_q  <= spi_ss_i;
            early_q   <= early_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            freq_q    <= freq_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
        end
    end

    assign cmd_ready_o    = ~full;
    assign busy_o         = (state_q != IDLE) | ~empty;
    assign spi_start_wr_o = (state_q == LAUNCH) & (rw_q == CMD_WR);
    assign spi_start_re_o = (state_q == LAUNCH) & (rw_q == CMD_RD);
    assign spi_addr_o     = addr_q;
    assign spi_wdata_o    = wdata_q;
    assign spi_freq_o     = freq_q;
    assign rsp_valid_o    = valid_q;
    assign rsp_rw_o       = rw_q;
    assign rsp_addr_o     = addr_q;
    assign rsp_rdata_o    = rdata_q;
    assign rsp_timeout_o  = timeout_q;
endmodule
